// File: rtl/prog_mem_loader.sv
// prog_mem_loader
// Writable instruction memory for the core. Clears itself to NOP_WORD after
// reset, then serves instruction fetch with one cycle of registered latency,
// and accepts a program download over a valid/ready loader port.
//
// Ports:
//   clk, rst      single clock, synchronous active-high reset
//   fetch_addr    instruction address from the PC
//   fetch_data    registered instruction word
//   fetch_valid   fetch_data holds real memory content (block in RUN)
//   busy          block is clearing or loading; the core must stall
//   load_start    one-cycle download request (base/len sampled with it)
//   load_base     first write address
//   load_len      number of words to write (0 completes immediately)
//   load_valid    load_data is presented
//   load_data     word to write
//   load_ready    block accepts a word this cycle
//   load_done     one-cycle pulse when a download completes
module prog_mem_loader #(
  parameter int                 DATA_W   = 14,
  parameter int                 ADDR_W   = 11,
  parameter int                 DEPTH    = 2048,
  parameter logic [DATA_W-1:0]  NOP_WORD = '0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] fetch_addr,
  output logic [DATA_W-1:0] fetch_data,
  output logic              fetch_valid,
  output logic              busy,
  input  logic              load_start,
  input  logic [ADDR_W-1:0] load_base,
  input  logic [ADDR_W:0]   load_len,
  input  logic              load_valid,
  input  logic [DATA_W-1:0] load_data,
  output logic              load_ready,
  output logic              load_done
);

  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);
  // DEPTH <= 2**ADDR_W, so it always fits in one extra bit.
  localparam logic [ADDR_W:0]   DEPTH_X   = (ADDR_W + 1)'(DEPTH);
  localparam logic [ADDR_W:0]   LEN_ONE   = (ADDR_W + 1)'(1);

  typedef enum logic [1:0] {
    S_CLEAR = 2'd0,
    S_RUN   = 2'd1,
    S_LOAD  = 2'd2
  } state_t;

  logic [DATA_W-1:0] mem [DEPTH];

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] clr_addr_q, clr_addr_d;
  logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
  logic [ADDR_W:0]   remaining_q, remaining_d;
  logic              done_q, done_d;

  logic              mem_we;
  logic [IDX_W-1:0]  mem_waddr;
  logic [DATA_W-1:0] mem_wdata;

  logic              wr_in_range;
  logic              fetch_in_range;

  assign wr_in_range    = ({1'b0, wr_addr_q} < DEPTH_X);
  assign fetch_in_range = ({1'b0, fetch_addr} < DEPTH_X);

  // Next-state, loader bookkeeping and the single memory write port.
  always_comb begin
    state_d     = state_q;
    clr_addr_d  = clr_addr_q;
    wr_addr_d   = wr_addr_q;
    remaining_d = remaining_q;
    done_d      = 1'b0;
    mem_we      = 1'b0;
    mem_waddr   = clr_addr_q[IDX_W-1:0];
    mem_wdata   = NOP_WORD;

    unique case (state_q)
      S_CLEAR: begin
        mem_we     = 1'b1;
        mem_waddr  = clr_addr_q[IDX_W-1:0];
        mem_wdata  = NOP_WORD;
        clr_addr_d = clr_addr_q + ADDR_W'(1);
        if (clr_addr_q == LAST_ADDR) begin
          state_d = S_RUN;
        end
      end

      S_RUN: begin
        if (load_start) begin
          wr_addr_d   = load_base;
          remaining_d = load_len;
          // A zero-length download completes without ever entering LOAD.
          if (load_len == '0) begin
            done_d = 1'b1;
          end else begin
            state_d = S_LOAD;
          end
        end
      end

      S_LOAD: begin
        if (load_valid) begin
          // Addresses beyond DEPTH have no storage; the word is dropped.
          mem_we      = wr_in_range;
          mem_waddr   = wr_addr_q[IDX_W-1:0];
          mem_wdata   = load_data;
          wr_addr_d   = (wr_addr_q == LAST_ADDR) ? '0 : wr_addr_q + ADDR_W'(1);
          remaining_d = remaining_q - LEN_ONE;
          if (remaining_q == LEN_ONE) begin
            state_d = S_RUN;
            done_d  = 1'b1;
          end
        end
      end

      default: begin
        state_d = S_CLEAR;
      end
    endcase
  end

  // Control registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_CLEAR;
      clr_addr_q <= '0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      clr_addr_q <= clr_addr_d;
      done_q     <= done_d;
    end
  end

  // Download pointer and count are always loaded before use.
  always_ff @(posedge clk) begin
    wr_addr_q   <= wr_addr_d;
    remaining_q <= remaining_d;
  end

  // Memory write port; reset aborts any in-flight write.
  always_ff @(posedge clk) begin
    if (mem_we && !rst) begin
      mem[mem_waddr] <= mem_wdata;
    end
  end

  // Fetch read port (registered, one cycle latency). Writes only happen
  // outside RUN, so a read never collides with a write.
  always_ff @(posedge clk) begin
    if (rst) begin
      fetch_data  <= NOP_WORD;
      fetch_valid <= 1'b0;
    end else if (state_q == S_RUN) begin
      fetch_valid <= 1'b1;
      fetch_data  <= fetch_in_range ? mem[fetch_addr[IDX_W-1:0]] : NOP_WORD;
    end else begin
      fetch_valid <= 1'b0;
      fetch_data  <= NOP_WORD;
    end
  end

  assign busy       = (state_q != S_RUN);
  assign load_ready = (state_q == S_LOAD);
  assign load_done  = done_q;

endmodule

// File: tb/tb_prog_mem_loader.sv
// Testbench for prog_mem_loader (DEPTH=16, ADDR_W=5, DATA_W=14).
// The driver issues one cycle of stimulus at a time and a reference model
// predicts every output for the following cycle; predictions are queued and
// a monitor on the falling edge pops and compares them.
module tb_prog_mem_loader;

  localparam int DW = 14;
  localparam int AW = 5;
  localparam int D  = 16;

  localparam int MC = 0;  // clearing
  localparam int MR = 1;  // running
  localparam int ML = 2;  // downloading

  logic          clk = 1'b0;
  logic          rst;
  logic [AW-1:0] fetch_addr;
  logic [DW-1:0] fetch_data;
  logic          fetch_valid;
  logic          busy;
  logic          load_start;
  logic [AW-1:0] load_base;
  logic [AW:0]   load_len;
  logic          load_valid;
  logic [DW-1:0] load_data;
  logic          load_ready;
  logic          load_done;

  prog_mem_loader #(
    .DATA_W   (DW),
    .ADDR_W   (AW),
    .DEPTH    (D),
    .NOP_WORD ('0)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .fetch_addr  (fetch_addr),
    .fetch_data  (fetch_data),
    .fetch_valid (fetch_valid),
    .busy        (busy),
    .load_start  (load_start),
    .load_base   (load_base),
    .load_len    (load_len),
    .load_valid  (load_valid),
    .load_data   (load_data),
    .load_ready  (load_ready),
    .load_done   (load_done)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic          fv;
    logic [DW-1:0] fd;
    logic          busy;
    logic          rdy;
    logic          done;
  } exp_t;

  exp_t exp_q[$];

  int total = 0;
  int bad   = 0;

  function automatic void chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, req, $time);
    end
  endfunction

  // Reference model state.
  int            m_mode;
  int            m_clear_cycles;
  int            m_addr;
  int            m_left;
  logic [DW-1:0] ref_mem [D];

  logic [DW-1:0] wbuf [64];
  logic [DW-1:0] prog9 [9];

  // Predict the outputs visible after the coming clock edge.
  task automatic model_step();
    exp_t e;
    e.fv   = 1'b0;
    e.fd   = '0;
    e.done = 1'b0;
    if (rst) begin
      m_mode         = MC;
      m_clear_cycles = 0;
    end else begin
      e.fv = (m_mode == MR);
      if (m_mode == MR && int'(fetch_addr) < D) e.fd = ref_mem[int'(fetch_addr)];
      case (m_mode)
        MC: begin
          m_clear_cycles++;
          if (m_clear_cycles == D) begin
            m_mode = MR;
            for (int i = 0; i < D; i++) ref_mem[i] = '0;
          end
        end
        MR: begin
          if (load_start) begin
            if (load_len == '0) begin
              e.done = 1'b1;
            end else begin
              m_mode = ML;
              m_addr = int'(load_base);
              m_left = int'(load_len);
            end
          end
        end
        default: begin
          if (load_valid) begin
            ref_mem[m_addr] = load_data;
            m_addr = (m_addr + 1) % D;
            m_left--;
            if (m_left == 0) begin
              m_mode = MR;
              e.done = 1'b1;
            end
          end
        end
      endcase
    end
    e.busy = (m_mode != MR);
    e.rdy  = (m_mode == ML);
    exp_q.push_back(e);
  endtask

  // One stimulus cycle: inputs are already set; predict, then advance.
  task automatic cycle();
    model_step();
    @(posedge clk);
    #1;
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      chk("fetch_valid", 32'(fetch_valid), 32'(e.fv));
      chk("fetch_data",  32'(fetch_data),  32'(e.fd));
      chk("busy",        32'(busy),        32'(e.busy));
      chk("load_ready",  32'(load_ready),  32'(e.rdy));
      chk("load_done",   32'(load_done),   32'(e.done));
    end
  end

  task automatic do_load(input int base, input int len, input int rst_after, input bit poke_start);
    int acc;
    int guard;
    acc   = 0;
    guard = 0;
    load_start = 1'b1;
    load_base  = AW'(base);
    load_len   = (AW + 1)'(len);
    cycle();
    load_start = 1'b0;
    while (m_mode == ML && guard < 400) begin
      guard++;
      if (rst_after >= 0 && acc == rst_after) begin
        load_valid = 1'b0;
        rst = 1'b1;
        cycle();
        rst = 1'b0;
      end else begin
        load_valid = ($urandom_range(0, 3) != 0);
        load_data  = wbuf[acc];
        fetch_addr = AW'($urandom);
        if (poke_start && $urandom_range(0, 2) == 0) begin
          load_start = 1'b1;
          load_base  = AW'(base + 7);
          load_len   = (AW + 1)'(2);
        end else begin
          load_start = 1'b0;
        end
        if (load_valid) acc++;
        cycle();
      end
    end
    load_valid = 1'b0;
    load_start = 1'b0;
    chk("load_bounded", 32'(guard < 400), 32'd1);
  endtask

  task automatic wait_run();
    int n;
    n = 0;
    while (m_mode != MR && n < 100) begin
      fetch_addr = AW'($urandom);
      cycle();
      n++;
    end
    chk("run_bounded", 32'(n < 100), 32'd1);
  endtask

  task automatic sweep();
    for (int a = 0; a < (1 << AW); a++) begin
      fetch_addr = AW'(a);
      cycle();
    end
    repeat (4) begin
      fetch_addr = AW'($urandom);
      cycle();
    end
  endtask

  task automatic fill_random(input int n);
    for (int i = 0; i < n; i++) wbuf[i] = DW'($urandom);
  endtask

  initial begin
    prog9[0] = 14'h0103; prog9[1] = 14'h01A5; prog9[2] = 14'h3003;
    prog9[3] = 14'h00A5; prog9[4] = 14'h3000; prog9[5] = 14'h3E01;
    prog9[6] = 14'h0BA5; prog9[7] = 14'h2805; prog9[8] = 14'h2808;

    rst        = 1'b1;
    fetch_addr = AW'(5);
    load_start = 1'b0;
    load_base  = '0;
    load_len   = '0;
    load_valid = 1'b0;
    load_data  = '0;

    // Reset, then the full clear pass with a fixed fetch address.
    repeat (2) cycle();
    rst = 1'b0;
    repeat (D + 4) cycle();

    // Program download with handshake gaps.
    for (int i = 0; i < 9; i++) wbuf[i] = prog9[i];
    do_load(0, 9, -1, 1'b0);
    sweep();

    // Download wrapping past the top of memory.
    fill_random(4);
    do_load(14, 4, -1, 1'b0);
    sweep();

    // Zero-length download.
    do_load(6, 0, -1, 1'b0);
    repeat (3) cycle();
    sweep();

    // Restart requests during a download are ignored.
    fill_random(6);
    do_load(3, 6, -1, 1'b1);
    sweep();

    // Reset part-way through a download.
    for (int i = 0; i < 9; i++) wbuf[i] = prog9[i];
    do_load(0, 9, 3, 1'b0);
    wait_run();
    sweep();

    // Random downloads, some longer than the memory.
    repeat (6) begin
      fill_random(24);
      do_load($urandom_range(0, D - 1), $urandom_range(0, 20), -1, 1'($urandom_range(0, 1)));
      repeat ($urandom_range(1, 6)) begin
        fetch_addr = AW'($urandom);
        cycle();
      end
    end
    sweep();

    @(negedge clk);
    #1;
    chk("queue_drained", 32'(exp_q.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/prog_mem_loader.md
# prog_mem_loader

Parametrised, writable program memory for the processor core. It replaces a fixed case-table ROM with a synchronous RAM that clears itself to `NOP_WORD` after reset and accepts a program download over a valid/ready loader port. It serves instruction fetch with one-cycle registered latency. It sits between the fetch stage, which drives `fetch_addr`, and the bootloader/UART front end, which drives `load_*`.

## Interface
- `DATA_W`, 14: instruction word width.
- `ADDR_W`, 11: fetch/load address width.
- `DEPTH`, 2048: number of words; `DEPTH` ≤ 2**`ADDR_W`.
- `NOP_WORD`, 0: clear value, and the value returned when fetch is not serviced.

- `clk`  in  1  the single clock; all state changes on the rising edge.
- `rst`  in  1  reset, synchronous and active-high.
- `fetch_addr`  in  `ADDR_W`  instruction address from the PC.
- `fetch_data`  out  `DATA_W`  registered instruction word.
- `fetch_valid`  out  1  `fetch_data` is real memory content.
- `busy`  out  1  block is in CLEAR or LOAD; the core must stall.
- `load_start`  in  1  one-cycle request to begin a download.
- `load_base`  in  `ADDR_W`  first write address, sampled with `load_start`.
- `load_len`  in  `ADDR_W`+1  word count, sampled with `load_start`; 0 is legal.
- `load_valid`  in  1  `load_data` is presented.
- `load_data`  in  `DATA_W`  word to write.
- `load_ready`  out  1  block accepts a word this cycle.
- `load_done`  out  1  one-cycle pulse when a download completes.

## Operation
- FSM states are CLEAR, RUN and LOAD. `rst` forces CLEAR and sets `clr_addr`=0.
- **CLEAR:**
  - Each cycle writes `NOP_WORD` to `mem[clr_addr]` and increments `clr_addr`.
  - The write to `DEPTH`-1 moves the FSM to RUN on the next edge.
  - `load_start` is ignored.
- **RUN:**
  - Fetch is serviced.
  - `load_start`=1 captures `wr_addr`←`load_base` and `remaining`←`load_len`, then moves to LOAD.
  - If `load_len`=0, the FSM stays in RUN and `load_done` pulses on the next cycle. No writes occur.
- **LOAD:**
  - `load_ready`=1.
  - Each cycle with `load_valid`&&`load_ready` writes `mem[wr_addr]`←`load_data`.
  - `wr_addr` increments modulo `DEPTH` (`DEPTH`-1 wraps to 0). `remaining` decrements.
  - Gaps in `load_valid` are allowed.
  - Accepting the word with `remaining`=1 returns the FSM to RUN and pulses `load_done` on the next cycle.
  - `load_start` is ignored.
- **Fetch:**
  - At each edge with the FSM in RUN and `fetch_addr` < `DEPTH`: `fetch_data`←`mem[fetch_addr]` and `fetch_valid`←1.
  - Otherwise (not in RUN, or out of range): `fetch_data`←`NOP_WORD`. `fetch_valid`←0 when not in RUN; it stays 1 for an out-of-range address in RUN.
- `busy` = (state ≠ RUN), decoded combinationally from the state register.
- Memory writes and fetch reads never coincide, so no read-during-write rule is needed.
- `rst` mid-CLEAR or mid-LOAD aborts immediately. A partial download is discarded and the CLEAR pass overwrites it. `load_done` is not pulsed.

## Timing
- Values on the first cycle after an edge with `rst`=1:
  - state=CLEAR
  - `fetch_data`=`NOP_WORD`
  - `fetch_valid`=0
  - `busy`=1
  - `load_ready`=0
  - `load_done`=0
- CLEAR lasts exactly `DEPTH` cycles. RUN is entered on cycle `DEPTH` after the reset edge, counting the first CLEAR cycle as 0.
- Fetch latency is 1 cycle: an address presented before edge N gives data valid after edge N.
- Load throughput is 1 word/cycle. `load_ready` is registered from the state and rises on the cycle after `load_start` is accepted.
- `load_done` rises on the cycle after the last word is accepted. That is the same cycle in which `busy` falls and `load_ready` falls.
- A fetch issued in the first RUN cycle after LOAD returns the newly written data.

## Test plan
- Reset with `DEPTH`=16, hold `fetch_addr`=5 → `busy`=1 for 16 cycles and `fetch_valid`=0. Then `fetch_valid`=1 and `fetch_data`=0x0000.
- Load at `load_base`=0, `load_len`=9 with words 0x0103,0x01A5,0x3003,0x00A5,0x3000,0x3E01,0x0BA5,0x2805,0x2808 and random `load_valid` gaps → exactly one `load_done` pulse. Fetching addresses 0..8 returns these words one cycle later; address 9 returns 0x0000.
- `DEPTH`=16, `load_base`=14, `load_len`=4 with words A,B,C,D → `mem[14]`=A, `mem[15]`=B, `mem[0]`=C, `mem[1]`=D. Address 2 stays 0x0000.
- `load_len`=0 → `load_ready` never rises, `load_done` pulses the following cycle, memory is unchanged.
- `load_start` pulsed again mid-LOAD with a different base → ignored; the original download completes at the original addresses.
- Assert `rst` after 3 of 9 words → CLEAR restarts with no `load_done`. After `DEPTH` cycles all addresses read 0x0000.
